serial_frame_deser: RTL and testbench



---
 rtl/serial_frame_deser.sv | 130 +++++++++++++
 tb/tb_serial_frame_deser.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deser.sv
// Serial-to-parallel frame deserializer: hunts for a sync word in an MSB-first
// bit stream, then emits FRAME_LEN data words on a registered valid/ready port.
module serial_frame_deser #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC      = 8'hA5,
  parameter int               FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             locked,
  output logic             overrun
);

  localparam int CW  = $clog2(WIDTH);
  localparam int WCW = $clog2(FRAME_LEN) + 1;

  localparam logic [CW-1:0]  BIT_MAX  = CW'(WIDTH - 1);
  localparam logic [WCW-1:0] WORD_MAX = WCW'(FRAME_LEN - 1);

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  // Only the low WIDTH-1 history bits are ever read; din supplies the newest bit.
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] nxt;

  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [CW-1:0]  hunt_cnt;
  logic [CW-1:0]  hunt_cnt_nxt;
  logic [CW-1:0]  bit_cnt;
  logic [CW-1:0]  bit_cnt_nxt;
  logic [WCW-1:0] word_cnt;
  logic [WCW-1:0] word_cnt_nxt;

  logic match;
  logic word_done;
  logic slot_free;
  logic xfer;
  logic last_word;

  assign nxt       = {shreg, din};
  assign match     = (state == ST_HUNT) && (hunt_cnt == BIT_MAX) && (nxt == SYNC);
  assign word_done = (state == ST_DATA) && (bit_cnt == BIT_MAX);
  assign last_word = (word_cnt == WORD_MAX);
  assign slot_free = !dout_valid || dout_ready;
  assign xfer      = dout_valid && dout_ready;

  always_comb begin
    state_nxt    = state;
    hunt_cnt_nxt = hunt_cnt;
    bit_cnt_nxt  = bit_cnt;
    word_cnt_nxt = word_cnt;
    case (state)
      ST_HUNT: begin
        if (hunt_cnt != BIT_MAX) begin
          hunt_cnt_nxt = hunt_cnt + CW'(1);
        end
        if (match) begin
          state_nxt    = ST_DATA;
          hunt_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          word_cnt_nxt = '0;
        end
      end
      default: begin
        // hunt_cnt is held at zero so a return to HUNT needs WIDTH fresh bits.
        hunt_cnt_nxt = '0;
        if (word_done) begin
          bit_cnt_nxt  = '0;
          word_cnt_nxt = word_cnt + WCW'(1);
          if (last_word) begin
            state_nxt = ST_HUNT;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      state    <= ST_HUNT;
      hunt_cnt <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      shreg    <= nxt[WIDTH-2:0];
      state    <= state_nxt;
      hunt_cnt <= hunt_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      word_cnt <= word_cnt_nxt;
      locked   <= (state_nxt == ST_DATA);
    end
  end

  // Output slot: a completing word loads if the slot is empty or being drained
  // this same edge; otherwise it is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done) begin
        if (slot_free) begin
          dout       <= nxt;
          dout_valid <= 1'b1;
          dout_last  <= last_word;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed self-checking bench for serial_frame_deser (WIDTH=8, SYNC=A5, FRAME_LEN=4).
module tb_serial_frame_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       dout_last;
  logic       locked;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int ocnt   = 0;
  int lcnt   = 0;

  serial_frame_deser #(
    .WIDTH    (8),
    .SYNC     (8'hA5),
    .FRAME_LEN(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last (dout_last),
    .locked    (locked),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, advance one clock, then sample just after the edge.
  task automatic tick(input logic b);
    din = b;
    @(posedge clk);
    #1;
    if (dout_valid) vcnt++;
    if (overrun) ocnt++;
    if (dout_last) lcnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(b[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
  endtask

  // One data word with ready high: valid must be low before the last bit and
  // present the word right after it.
  task automatic data_word(input logic [7:0] b, input logic is_last);
    for (int i = 7; i >= 1; i--) tick(b[i]);
    check("nom_pre_valid", dout_valid, 0);
    tick(b[0]);
    check("nom_valid", dout_valid, 1);
    check("nom_dout", dout, b);
    check("nom_last", dout_last, is_last);
    check("nom_locked", locked, !is_last);
  endtask

  initial begin
    logic [47:0] ms;
    logic [7:0]  sync_b;
    logic [7:0]  mis_exp [4];
    int          n;

    mis_exp = '{8'h01, 8'h12, 8'h23, 8'h34};
    sync_b  = 8'hA5;

    // Reset held with random din
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'($urandom));
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_last", dout_last, 0);
    check("rst_locked", locked, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;

    // Nominal frame
    do_reset();
    dout_ready = 1'b1;
    vcnt = 0; ocnt = 0; lcnt = 0;
    for (int i = 7; i >= 1; i--) tick(sync_b[i]);
    check("nom_prelock", locked, 0);
    tick(sync_b[0]);
    check("nom_lock", locked, 1);
    check("nom_lock_valid", dout_valid, 0);
    data_word(8'h12, 1'b0);
    data_word(8'h34, 1'b0);
    data_word(8'h56, 1'b0);
    data_word(8'h78, 1'b1);
    tick(1'b0);
    check("nom_post_valid", dout_valid, 0);
    check("nom_post_last", dout_last, 0);
    check("nom_post_locked", locked, 0);
    check("nom_vcnt", vcnt, 4);
    check("nom_lcnt", lcnt, 1);
    check("nom_ocnt", ocnt, 0);

    // Misaligned sync: 0A 50 11 22 33 44
    do_reset();
    dout_ready = 1'b1;
    vcnt = 0; ocnt = 0; lcnt = 0;
    ms = 48'h0A50_1122_3344;
    for (int i = 47; i >= 0; i--) begin
      tick(ms[i]);
      n = 48 - i;
      if (n == 11) check("mis_prelock", locked, 0);
      if (n == 12) check("mis_lock", locked, 1);
      if (n > 12 && ((n - 12) % 8) == 0) begin
        check("mis_valid", dout_valid, 1);
        check("mis_dout", dout, mis_exp[(n - 12) / 8 - 1]);
        check("mis_last", dout_last, (n == 44));
      end
    end
    check("mis_vcnt", vcnt, 4);
    check("mis_locked_end", locked, 0);

    // Back-pressure
    do_reset();
    dout_ready = 1'b0;
    vcnt = 0; ocnt = 0; lcnt = 0;
    send_byte(8'hA5);
    send_byte(8'h12);
    check("bp_valid", dout_valid, 1);
    check("bp_dout", dout, 8'h12);
    check("bp_ovr_first", overrun, 0);
    send_byte(8'h34);
    check("bp_ovr_pulse", overrun, 1);
    check("bp_dout_held", dout, 8'h12);
    check("bp_last_held", dout_last, 0);
    send_byte(8'h56);
    send_byte(8'h78);
    tick(1'b0);
    check("bp_ocnt", ocnt, 3);
    check("bp_ovr_low", overrun, 0);
    check("bp_dout_end", dout, 8'h12);
    check("bp_valid_end", dout_valid, 1);
    check("bp_last_end", dout_last, 0);
    check("bp_lcnt", lcnt, 0);
    check("bp_locked_end", locked, 0);
    dout_ready = 1'b1;
    tick(1'b0);
    check("bp_drain", dout_valid, 0);

    // Simultaneous accept and complete
    do_reset();
    dout_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h12);
    check("sim_dout12", dout, 8'h12);
    vcnt = 0; ocnt = 0;
    for (int i = 7; i >= 1; i--) tick(1'((8'h34 >> i) & 8'h01));
    dout_ready = 1'b1;
    tick(1'b0);
    dout_ready = 1'b0;
    check("sim_valid", dout_valid, 1);
    check("sim_dout34", dout, 8'h34);
    check("sim_vcnt", vcnt, 8);
    check("sim_ocnt", ocnt, 0);

    // Reset mid-frame, asserted between edges
    do_reset();
    dout_ready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h12);
    check("mid_dout12", dout, 8'h12);
    send_byte(8'h34);
    check("mid_dout34", dout, 8'h34);
    check("mid_locked_pre", locked, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_locked", locked, 0);
    check("mid_async_valid", dout_valid, 0);
    check("mid_async_dout", dout, 0);
    tick(1'b0);
    rst = 1'b0;
    vcnt = 0; lcnt = 0; ocnt = 0;
    send_byte(8'h56);
    send_byte(8'h78);
    check("mid_orphan_vcnt", vcnt, 0);
    check("mid_orphan_locked", locked, 0);
    send_byte(8'hA5);
    check("mid_relock", locked, 1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    check("mid_dout78", dout, 8'h78);
    check("mid_last78", dout_last, 1);
    check("mid_locked_end", locked, 0);
    tick(1'b0);
    check("mid_vcnt", vcnt, 4);
    check("mid_lcnt", lcnt, 1);
    check("mid_ocnt", ocnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
